// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared stage indices and PC defaults for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam int StageIF  = 0;
  localparam int StageID  = 1;
  localparam int StageEX  = 2;
  localparam int StageMEM = 3;
  localparam int StageWB  = 4;

  localparam int DEFAULT_PC_STEP  = 4;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/redirect requests in, PC and per-stage controls out
interface pipeline_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
);
  logic [NSTAGE-1:0] stallreq_i;
  logic              branch_i;
  logic [PC_W-1:0]   branch_pc_i;
  logic              flush_i;
  logic [PC_W-1:0]   flush_pc_i;
  logic [PC_W-1:0]   pc_o;
  logic              ce_o;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] bubble_o;
  logic              flush_o;
  logic [NSTAGE-1:0] valid_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  modport master (
    output stallreq_i, branch_i, branch_pc_i, flush_i, flush_pc_i,
    input  pc_o, ce_o, stall_o, bubble_o, flush_o, valid_o, stall_cnt_o, retire_cnt_o
  );

  modport slave (
    input  stallreq_i, branch_i, branch_pc_i, flush_i, flush_pc_i,
    output pc_o, ce_o, stall_o, bubble_o, flush_o, valid_o, stall_cnt_o, retire_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - W-bit up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - PC sequencing plus stall/bubble/flush arbitration and valid tracking
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int              NSTAGE   = 5,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(DEFAULT_PC_STEP),
  parameter int              CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);

  logic [NSTAGE-1:0] stall_raw;
  logic [NSTAGE-1:0] bubble_raw;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic [NSTAGE-1:0] valid;
  logic [NSTAGE-1:1] valid_hi;
  logic [PC_W-1:0]   pc;
  logic              ce;

  // Latch i holds when any stage at or beyond i requests; the latch just past
  // the highest requester is the only one that takes a bubble.
  for (genvar i = 0; i < NSTAGE; i++) begin : g_prio
    assign stall_raw[i] = |bus.stallreq_i[NSTAGE-1:i];
    if (i == 0) begin : g_first
      assign bubble_raw[i] = 1'b0;
    end else begin : g_rest
      assign bubble_raw[i] = bus.stallreq_i[i-1] & ~stall_raw[i];
    end
  end

  assign stall  = bus.flush_i ? '0 : stall_raw;
  assign bubble = bus.flush_i ? '0 : bubble_raw;
  assign valid  = {valid_hi, ce};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce <= 1'b0;
      pc <= RESET_PC;
    end else begin
      ce <= 1'b1;
      // PC is held on the edge where ce rises so RESET_PC is the first fetch.
      if (ce) begin
        if (bus.flush_i) begin
          pc <= bus.flush_pc_i;
        end else if (!stall[StageIF]) begin
          pc <= bus.branch_i ? bus.branch_pc_i : pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_hi <= '0;
    end else begin
      for (int i = 1; i < NSTAGE; i++) begin
        if (bus.flush_i) begin
          valid_hi[i] <= 1'b0;
        end else if (stall[i]) begin
          valid_hi[i] <= valid_hi[i];
        end else if (bubble[i]) begin
          valid_hi[i] <= 1'b0;
        end else begin
          valid_hi[i] <= valid[i-1];
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (|stall),
    .cnt (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .inc (valid[NSTAGE-1]),
    .cnt (bus.retire_cnt_o)
  );

  assign bus.pc_o     = pc;
  assign bus.ce_o     = ce;
  assign bus.stall_o  = stall;
  assign bus.bubble_o = bubble;
  assign bus.flush_o  = bus.flush_i;
  assign bus.valid_o  = valid;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector table plus hand sequences for pipeline_ctrl
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.NSTAGE(5), .PC_W(32), .CNT_W(32)) bus ();
  pipeline_ctrl_if #(.NSTAGE(5), .PC_W(8),  .CNT_W(4))  bus2 ();

  pipeline_ctrl #(.NSTAGE(5), .PC_W(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_ctrl #(.NSTAGE(5), .PC_W(8), .CNT_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [4:0]  req;
    logic        fl;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] fpc;
    logic [4:0]  e_stall;
    logic [4:0]  e_bubble;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [4:0]  e_valid;
    logic [31:0] e_sc;
    logic [31:0] e_rc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // req    fl  br  bpc     fpc    stall    bubble   fl  pc      valid    sc  rc
    tbl[0]  = '{5'b00100, 0, 0, 32'h0,   32'h0,  5'b00111, 5'b01000, 0, 32'h10,  5'b10111, 1, 1};
    tbl[1]  = '{5'b00100, 0, 0, 32'h0,   32'h0,  5'b00111, 5'b01000, 0, 32'h10,  5'b00111, 2, 2};
    tbl[2]  = '{5'b00000, 0, 0, 32'h0,   32'h0,  5'b00000, 5'b00000, 0, 32'h14,  5'b01111, 2, 2};
    tbl[3]  = '{5'b00000, 0, 1, 32'h100, 32'h0,  5'b00000, 5'b00000, 0, 32'h100, 5'b11111, 2, 2};
    tbl[4]  = '{5'b00000, 0, 0, 32'h0,   32'h0,  5'b00000, 5'b00000, 0, 32'h104, 5'b11111, 2, 3};
    tbl[5]  = '{5'b00010, 0, 1, 32'h200, 32'h0,  5'b00011, 5'b00100, 0, 32'h104, 5'b11011, 3, 4};
    tbl[6]  = '{5'b00000, 0, 1, 32'h200, 32'h0,  5'b00000, 5'b00000, 0, 32'h200, 5'b10111, 3, 5};
    tbl[7]  = '{5'b00000, 0, 0, 32'h0,   32'h0,  5'b00000, 5'b00000, 0, 32'h204, 5'b01111, 3, 6};
    tbl[8]  = '{5'b01000, 1, 1, 32'h300, 32'h80, 5'b00000, 5'b00000, 1, 32'h80,  5'b00001, 3, 6};
    tbl[9]  = '{5'b00000, 0, 0, 32'h0,   32'h0,  5'b00000, 5'b00000, 0, 32'h84,  5'b00011, 3, 6};
    tbl[10] = '{5'b10000, 0, 0, 32'h0,   32'h0,  5'b11111, 5'b00000, 0, 32'h84,  5'b00011, 4, 6};
    tbl[11] = '{5'b01001, 0, 0, 32'h0,   32'h0,  5'b01111, 5'b10000, 0, 32'h84,  5'b00011, 5, 6};
    tbl[12] = '{5'b00000, 0, 0, 32'h0,   32'h0,  5'b00000, 5'b00000, 0, 32'h88,  5'b00111, 5, 6};

    bus.stallreq_i  = '0;
    bus.branch_i    = 1'b0;
    bus.branch_pc_i = '0;
    bus.flush_i     = 1'b0;
    bus.flush_pc_i  = '0;
    bus2.stallreq_i  = '0;
    bus2.branch_i    = 1'b0;
    bus2.branch_pc_i = '0;
    bus2.flush_i     = 1'b0;
    bus2.flush_pc_i  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc_o, 32'h0);
    chk("reset_ce", 32'(bus.ce_o), 32'h0);
    chk("reset_valid", 32'(bus.valid_o), 32'h0);
    chk("reset_stall", 32'(bus.stall_o), 32'h0);
    chk("reset_bubble", 32'(bus.bubble_o), 32'h0);
    chk("reset_flush", 32'(bus.flush_o), 32'h0);
    chk("reset_sc", bus.stall_cnt_o, 32'h0);
    chk("reset_rc", bus.retire_cnt_o, 32'h0);

    rst = 1'b0;
    tick();
    chk("e1_ce", 32'(bus.ce_o), 32'h1);
    chk("e1_pc", bus.pc_o, 32'h0);
    tick();
    chk("e2_pc", bus.pc_o, 32'h4);
    tick();
    chk("e3_pc", bus.pc_o, 32'h8);
    tick();
    chk("e4_pc", bus.pc_o, 32'hC);
    tick();
    chk("e5_pc", bus.pc_o, 32'h10);
    chk("e5_valid", 32'(bus.valid_o), 32'h1F);
    chk("e5_rc", bus.retire_cnt_o, 32'h0);

    for (int v = 0; v < 13; v++) begin
      bus.stallreq_i  = tbl[v].req;
      bus.flush_i     = tbl[v].fl;
      bus.branch_i    = tbl[v].br;
      bus.branch_pc_i = tbl[v].bpc;
      bus.flush_pc_i  = tbl[v].fpc;
      #1;
      chk($sformatf("v%0d_stall", v), 32'(bus.stall_o), 32'(tbl[v].e_stall));
      chk($sformatf("v%0d_bubble", v), 32'(bus.bubble_o), 32'(tbl[v].e_bubble));
      chk($sformatf("v%0d_flush", v), 32'(bus.flush_o), 32'(tbl[v].e_flush));
      tick();
      chk($sformatf("v%0d_pc", v), bus.pc_o, tbl[v].e_pc);
      chk($sformatf("v%0d_valid", v), 32'(bus.valid_o), 32'(tbl[v].e_valid));
      chk($sformatf("v%0d_sc", v), bus.stall_cnt_o, tbl[v].e_sc);
      chk($sformatf("v%0d_rc", v), bus.retire_cnt_o, tbl[v].e_rc);
    end
    bus.stallreq_i = '0;
    bus.flush_i    = 1'b0;
    bus.branch_i   = 1'b0;

    // asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc_o, 32'h0);
    chk("arst_ce", 32'(bus.ce_o), 32'h0);
    chk("arst_valid", 32'(bus.valid_o), 32'h0);
    chk("arst_sc", bus.stall_cnt_o, 32'h0);
    chk("arst_rc", bus.retire_cnt_o, 32'h0);
    tick();
    rst = 1'b0;

    // narrow instance: PC wrap and counter saturation
    tick();
    chk("w_ce", 32'(bus2.ce_o), 32'h1);
    chk("w_pc0", 32'(bus2.pc_o), 32'h0);
    bus2.flush_i    = 1'b1;
    bus2.flush_pc_i = 8'hFC;
    #1;
    chk("w_flush", 32'(bus2.flush_o), 32'h1);
    tick();
    bus2.flush_i = 1'b0;
    chk("w_pc_fc", 32'(bus2.pc_o), 32'hFC);
    tick();
    chk("w_pc_wrap", 32'(bus2.pc_o), 32'h0);
    bus2.stallreq_i = 5'b00001;
    #1;
    chk("w_stall", 32'(bus2.stall_o), 32'h01);
    chk("w_bubble", 32'(bus2.bubble_o), 32'h02);
    repeat (14) tick();
    chk("w_sc14", 32'(bus2.stall_cnt_o), 32'd14);
    repeat (6) tick();
    chk("w_sc_sat", 32'(bus2.stall_cnt_o), 32'd15);
    chk("w_pc_held", 32'(bus2.pc_o), 32'h0);
    bus2.stallreq_i = '0;
    tick();
    chk("w_pc_resume", 32'(bus2.pc_o), 32'h4);
    chk("w_sc_hold", 32'(bus2.stall_cnt_o), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline control block for the Sirius core: owns the PC register and generates per-stage stall, bubble, flush and valid signals for an NSTAGE-deep in-order pipeline. It takes over PC sequencing and stall/flush arbitration, which today are fixed at five stages with no hazard control, so the core top can add stall-capable stages and a redirect path. Two saturating performance counters are included:

- cycles with any stall;
- retired (WB-valid) cycles.

## Interface
Parameters:
- NSTAGE, 5, number of pipeline stages; stage 0 = IF, stage NSTAGE-1 = WB; minimum 3
- PC_W, 32, PC width
- RESET_PC, 0, PC value held during and after reset
- PC_STEP, 4, sequential PC increment
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stallreq_i  in  NSTAGE  bit s = stage s requests a stall this cycle
- branch_i  in  1  redirect request from stage 1 (ID)
- branch_pc_i  in  PC_W  redirect target
- flush_i  in  1  pipeline flush (exception/replay)
- flush_pc_i  in  PC_W  flush target
- pc_o  out  PC_W  fetch address
- ce_o  out  1  fetch enable
- stall_o  out  NSTAGE  bit i = latch i holds; latch 0 = PC, latch i = register feeding stage i
- bubble_o  out  NSTAGE  bit i = latch i loads a NOP/invalid next edge
- flush_o  out  1  all stage registers clear next edge
- valid_o  out  NSTAGE  per-latch valid bits
- stall_cnt_o  out  CNT_W  saturating count of cycles with any stall_o bit set
- retire_cnt_o  out  CNT_W  saturating count of cycles with valid_o[NSTAGE-1]=1

## Operation
- **Stall arbitration:**
  - s = highest index with stallreq_i[s]=1.
  - stall_o[i]=1 for i≤s.
  - bubble_o[s+1]=1 if s+1<NSTAGE.
  - Otherwise bubble_o=0.
  - With no request, stall_o=0 and bubble_o=0.
- **Priority:** flush > stall > branch > sequential.
  - flush_i: flush_o=1, stall_o=0, bubble_o=0; next edge PC←flush_pc_i, valid_o[NSTAGE-1:1]←0.
  - branch_i while stall_o[0]=1 is ignored; ID re-presents it after the stall.
  - branch_i otherwise: next edge PC←branch_pc_i.
  - Sequential: PC←PC+PC_STEP, modulo 2^PC_W (wraps without flag).
- **Valid pipeline:**
  - valid_o[0]=ce_o.
  - For i≥1 the next value is, in priority order: flush→0; stall_o[i]→hold; bubble_o[i]→0; else valid_o[i-1].
- **Counters:** increment by 1 per qualifying cycle and saturate at 2^CNT_W−1. Flush does not clear them.
- **ce_o:** 0 in reset; 1 from the first edge after reset deasserts, then stays 1.
  - PC does not advance on the edge where ce_o rises, so the first fetch address is RESET_PC.

## Timing
- Reset values:
  - pc_o=RESET_PC, ce_o=0, valid_o=0, counters=0.
  - stall_o, bubble_o and flush_o are combinational from inputs, so they are 0 if inputs are 0.
- Asserting rst mid-operation clears all registers immediately, asynchronously.
- stall_o, bubble_o, flush_o: zero-latency combinational from stallreq_i/flush_i.
- pc_o, valid_o, counters: registered, 1-cycle latency.
- Redirect penalty: on the edge after branch_i, pc_o=branch_pc_i. The slot already fetched is not squashed by this block; delay-slot semantics.
- Simultaneous flush_i + stallreq_i + branch_i: only the flush acts; stall counter does not count that cycle.
- Stall held N cycles → pc_o constant for N cycles and stall_cnt_o += N.

## Structure
- Add stage-index constants (StageIF, StageID, StageEX, StageMEM, StageWB) and the default PC_STEP/RESET_PC to the shared defines.v.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt). Instantiated twice.
- Priority encoder for s is a generate loop inside pipeline_ctrl, not a separate module.

## Test plan
- **Reset release:** hold rst 3 cycles, then release.
  - During reset: pc_o=0, ce_o=0.
  - Edge 1: ce_o=1, pc_o=0.
  - Edge 2: pc_o=4. Edge 3: pc_o=8.
- **EX stall:** stallreq_i=5'b00100 for 2 cycles.
  - stall_o=5'b00111 and bubble_o=5'b01000.
  - pc_o frozen 2 cycles; valid_o[3]=0 on the following edge.
  - stall_cnt_o=2.
- **Branch:** branch_i=1, branch_pc_i=0x100 with no stall → next pc_o=0x100, then 0x104.
- **Branch during ID stall:** stallreq_i=5'b00010 and branch_i=1 → pc_o unchanged; after the stall drops with branch_i=1, pc_o=target.
- **Flush collision:** flush_i=1 with flush_pc_i=0x80, stallreq_i=5'b01000 and branch_i=1 in the same cycle.
  - flush_o=1, stall_o=0.
  - Next edge: pc_o=0x80, valid_o[4:1]=0.
  - stall_cnt_o unchanged.
- **Saturation/wrap (CNT_W=4, PC_W=8):**
  - 20 stall cycles → stall_cnt_o=15.
  - PC from 0xFC increments to 0x00.
